// File: rtl/oled_pkg.sv
// oled_pkg: shared types and register map for the OLED stream manager.
// Imported by the byte FIFO and the top-level slave.
package oled_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_TXDATA = 3'd2;
  localparam logic [2:0] REG_TXCMD  = 3'd3;
  localparam logic [2:0] REG_COLOUR = 3'd4;
  localparam logic [2:0] REG_FILL   = 3'd5;
  localparam logic [2:0] REG_FLUSH  = 3'd6;

  typedef struct packed {
    logic       dnc;
    logic [7:0] data;
  } fifo_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    LOW,
    HIGH
  } ser_state_t;

endpackage

// File: rtl/oled_byte_fifo.sv
// oled_byte_fifo: synchronous FIFO of command/data bytes for the SPI link.
// Flush wins over push and pop; dout is the head entry, valid when !empty.
module oled_byte_fifo
  import oled_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic                        flush,
  input  fifo_entry_t                 din,
  output fifo_entry_t                 dout,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  fifo_entry_t   mem_q [FIFO_DEPTH];
  fifo_entry_t   mem_d [FIFO_DEPTH];
  logic          do_push;
  logic          do_pop;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign level = cnt_q;
  assign dout  = mem_q[rd_q];

  // Next pointer/count/storage values
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    do_push = push & ~full & ~flush;
    do_pop  = pop & ~empty & ~flush;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = din;
        wr_d        = wr_q + AW'(1);
      end
      if (do_pop) begin
        rd_d = rd_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and storage registers
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/oled_stream_manager.sv
// oled_stream_manager: AHB-Lite slave feeding a buffered 4-wire SPI OLED
// link with a programmable SCLK rate and a rectangle-fill engine.
module oled_stream_manager
  import oled_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 8,
  parameter int FILL_WIDTH = 16
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic        HWRITE,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        nCS,
  output logic        DnC,
  output logic        SDIN,
  output logic        SCLK
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  // Bus address phase
  logic       aph_valid_q, aph_valid_d;
  logic       aph_write_q, aph_write_d;
  logic [2:0] aph_idx_q, aph_idx_d;

  // Programmer-visible state
  logic                  enable_q, enable_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [15:0]           colour_q, colour_d;
  logic                  overflow_q, overflow_d;
  logic                  fill_err_q, fill_err_d;
  logic                  fill_active_q, fill_active_d;
  logic                  fill_hi_q, fill_hi_d;
  logic [FILL_WIDTH-1:0] fill_cnt_q, fill_cnt_d;

  // Serializer
  ser_state_t           state_q, state_d;
  logic [2:0]           bit_q, bit_d;
  logic [DIV_WIDTH-1:0] phase_q, phase_d;
  logic [DIV_WIDTH-1:0] div_lat_q, div_lat_d;
  logic [7:0]           shift_q, shift_d;
  logic                 ncs_q, ncs_d;
  logic                 dnc_q, dnc_d;
  logic                 sdin_q, sdin_d;
  logic                 sclk_q, sclk_d;

  // Decode and FIFO glue
  logic                  wr_en, rd_en;
  logic                  wr_ctrl, wr_status, wr_txdata, wr_txcmd;
  logic                  wr_colour, wr_fill, wr_flush;
  logic                  ahb_push, fill_push, flush;
  logic                  fifo_push, ser_pop, do_load, start;
  logic                  fifo_full, fifo_empty;
  logic [LW-1:0]         fifo_level;
  fifo_entry_t           fifo_din, fifo_dout;
  logic [FILL_WIDTH-1:0] fill_n;
  logic                  busy;
  logic                  unused_ok;

  assign unused_ok = ^{HSIZE, HADDR[31:5], HADDR[1:0], HWDATA};

  assign wr_en     = aph_valid_q & aph_write_q;
  assign rd_en     = aph_valid_q & ~aph_write_q;
  assign wr_ctrl   = wr_en & (aph_idx_q == REG_CTRL);
  assign wr_status = wr_en & (aph_idx_q == REG_STATUS);
  assign wr_txdata = wr_en & (aph_idx_q == REG_TXDATA);
  assign wr_txcmd  = wr_en & (aph_idx_q == REG_TXCMD);
  assign wr_colour = wr_en & (aph_idx_q == REG_COLOUR);
  assign wr_fill   = wr_en & (aph_idx_q == REG_FILL);
  assign wr_flush  = wr_en & (aph_idx_q == REG_FLUSH);

  assign fill_n    = HWDATA[FILL_WIDTH-1:0];
  assign ahb_push  = wr_txdata | wr_txcmd;
  assign flush     = wr_flush & HWDATA[0];
  assign fill_push = fill_active_q & ~ahb_push & ~fifo_full & ~flush;
  assign fifo_push = (ahb_push & ~fifo_full) | fill_push;
  assign busy      = (state_q != IDLE) | ~fifo_empty;

  assign HREADYOUT = 1'b1;
  assign nCS       = ncs_q;
  assign DnC       = dnc_q;
  assign SDIN      = sdin_q;
  assign SCLK      = sclk_q;

  oled_byte_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (HCLK),
    .rst  (HRESET),
    .push (fifo_push),
    .pop  (ser_pop),
    .flush(flush),
    .din  (fifo_din),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty),
    .level(fifo_level)
  );

  // Capture the address phase; an idle or deselected cycle clears it
  always_comb begin
    aph_valid_d = HSEL & HREADY & (HTRANS != 2'b00);
    aph_write_d = HWRITE;
    aph_idx_d   = HADDR[4:2];
  end

  // Register writes, sticky flags and the fill engine
  always_comb begin
    enable_d      = enable_q;
    div_d         = div_q;
    colour_d      = colour_q;
    overflow_d    = overflow_q;
    fill_err_d    = fill_err_q;
    fill_active_d = fill_active_q;
    fill_hi_d     = fill_hi_q;
    fill_cnt_d    = fill_cnt_q;
    fifo_din.dnc  = 1'b1;
    fifo_din.data = fill_hi_q ? colour_q[15:8] : colour_q[7:0];
    if (ahb_push) begin
      fifo_din.dnc  = wr_txdata;
      fifo_din.data = HWDATA[7:0];
    end
    if (wr_ctrl) begin
      enable_d = HWDATA[0];
      div_d    = HWDATA[8 +: DIV_WIDTH];
    end
    if (wr_colour) begin
      colour_d = HWDATA[15:0];
    end
    if (ahb_push & fifo_full) begin
      overflow_d = 1'b1;
    end
    if (wr_status & HWDATA[4]) begin
      overflow_d = 1'b0;
    end
    if (fill_push) begin
      if (fill_hi_q) begin
        fill_hi_d = 1'b0;
      end else begin
        fill_hi_d  = 1'b1;
        fill_cnt_d = fill_cnt_q - FILL_WIDTH'(1);
        if (fill_cnt_q == FILL_WIDTH'(1)) begin
          fill_active_d = 1'b0;
        end
      end
    end
    if (wr_fill) begin
      if (fill_active_q) begin
        fill_err_d = 1'b1;
      end else if (fill_n != '0) begin
        fill_active_d = 1'b1;
        fill_hi_d     = 1'b1;
        fill_cnt_d    = fill_n;
      end
    end
    if (wr_status & HWDATA[5]) begin
      fill_err_d = 1'b0;
    end
    if (flush) begin
      fill_active_d = 1'b0;
    end
  end

  // Serializer next state and registered pin values
  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    phase_d   = phase_q;
    div_lat_d = div_lat_q;
    shift_d   = shift_q;
    ncs_d     = ncs_q;
    dnc_d     = dnc_q;
    sdin_d    = sdin_q;
    sclk_d    = sclk_q;
    do_load   = 1'b0;
    start     = enable_q & ~fifo_empty;
    unique case (state_q)
      IDLE: begin
        do_load = start;
      end
      LOAD: begin
        state_d = LOW;
        phase_d = '0;
      end
      LOW: begin
        if (phase_q == div_lat_q) begin
          phase_d = '0;
          sclk_d  = 1'b1;
          state_d = HIGH;
        end else begin
          phase_d = phase_q + DIV_WIDTH'(1);
        end
      end
      HIGH: begin
        if (phase_q == div_lat_q) begin
          phase_d = '0;
          sclk_d  = 1'b0;
          if (bit_q != 3'd7) begin
            bit_d   = bit_q + 3'd1;
            shift_d = {shift_q[6:0], 1'b0};
            sdin_d  = shift_q[6];
            state_d = LOW;
          end else if (start) begin
            do_load = 1'b1;
          end else begin
            state_d = IDLE;
            ncs_d   = 1'b1;
            sdin_d  = 1'b0;
          end
        end else begin
          phase_d = phase_q + DIV_WIDTH'(1);
        end
      end
    endcase
    ser_pop = do_load;
    if (do_load) begin
      state_d   = LOAD;
      shift_d   = fifo_dout.data;
      dnc_d     = fifo_dout.dnc;
      sdin_d    = fifo_dout.data[7];
      ncs_d     = 1'b0;
      sclk_d    = 1'b0;
      bit_d     = '0;
      phase_d   = '0;
      div_lat_d = div_q;
    end
  end

  // Read mux for the data phase of a read
  always_comb begin
    HRDATA = '0;
    if (rd_en) begin
      case (aph_idx_q)
        REG_CTRL: begin
          HRDATA[0]              = enable_q;
          HRDATA[8 +: DIV_WIDTH] = div_q;
        end
        REG_STATUS: begin
          HRDATA[0]       = busy;
          HRDATA[1]       = fifo_full;
          HRDATA[2]       = fifo_empty;
          HRDATA[3]       = fill_active_q;
          HRDATA[4]       = overflow_q;
          HRDATA[5]       = fill_err_q;
          HRDATA[16 +: LW] = fifo_level;
        end
        REG_COLOUR: begin
          HRDATA[15:0] = colour_q;
        end
        default: HRDATA = '0;
      endcase
    end
  end

  // Bus-side registers
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      aph_valid_q   <= 1'b0;
      aph_write_q   <= 1'b0;
      aph_idx_q     <= '0;
      enable_q      <= 1'b0;
      div_q         <= '0;
      colour_q      <= '0;
      overflow_q    <= 1'b0;
      fill_err_q    <= 1'b0;
      fill_active_q <= 1'b0;
      fill_hi_q     <= 1'b0;
      fill_cnt_q    <= '0;
    end else begin
      aph_valid_q   <= aph_valid_d;
      aph_write_q   <= aph_write_d;
      aph_idx_q     <= aph_idx_d;
      enable_q      <= enable_d;
      div_q         <= div_d;
      colour_q      <= colour_d;
      overflow_q    <= overflow_d;
      fill_err_q    <= fill_err_d;
      fill_active_q <= fill_active_d;
      fill_hi_q     <= fill_hi_d;
      fill_cnt_q    <= fill_cnt_d;
    end
  end

  // Serializer state register and output pins
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q   <= IDLE;
      bit_q     <= '0;
      phase_q   <= '0;
      div_lat_q <= '0;
      shift_q   <= '0;
      ncs_q     <= 1'b1;
      dnc_q     <= 1'b0;
      sdin_q    <= 1'b0;
      sclk_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_q     <= bit_d;
      phase_q   <= phase_d;
      div_lat_q <= div_lat_d;
      shift_q   <= shift_d;
      ncs_q     <= ncs_d;
      dnc_q     <= dnc_d;
      sdin_q    <= sdin_d;
      sclk_q    <= sclk_d;
    end
  end

endmodule
